dcache_sram_nway: RTL and testbench
===================================

Name: dcache_sram_nway

Overview:
Parametrised N-way set-associative data-cache storage array with true-LRU replacement, the successor to the 2-way dcache SRAM. It keeps the same lookup and fill contract with the dcache controller: combinational lookup, clocked write, and victim line presented on a miss. It adds configurable ways, sets, tag and line widths, and a hardware flush/invalidate walker with a valid/ready write-back port toward memory.

Parameters:
WAYS, 4, associativity; power of two, 2..8; WAY_W = clog2(WAYS)
SETS, 16, number of sets; power of two, 2..256; IDX_W = clog2(SETS)
TAG_W, 23, address tag width; stored entry is TAG_W+2 bits: bit TAG_W+1 valid, bit TAG_W dirty, bits TAG_W-1:0 tag
LINE_W, 256, cache line width in bits

Ports:
clk_i  in  1  clock; single clock domain
rst_i  in  1  synchronous, active-high reset
addr_i  in  IDX_W  set index
tag_i  in  TAG_W+2  {valid, dirty, tag} to compare and write
data_i  in  LINE_W  line to write
enable_i  in  1  access request
write_i  in  1  access is a write (hit update or miss fill)
tag_o  out  TAG_W+2  hit-way entry on hit, victim entry on miss
data_o  out  LINE_W  hit-way line on hit, victim line on miss
hit_o  out  1  lookup hit
way_o  out  WAY_W  hit way on hit, victim way on miss
flush_i  in  1  start flush (sampled in IDLE only)
flush_inv_i  in  1  sampled with flush_i; 1 = also invalidate every entry
flush_busy_o  out  1  walker active
flush_valid_o  out  1  dirty line offered for write-back
flush_ready_i  in  1  memory side accepts offered line
flush_set_o  out  IDX_W  set of offered line
flush_tag_o  out  TAG_W  tag of offered line
flush_data_o  out  LINE_W  offered line
flush_done_o  out  1  one-cycle pulse at flush end

Behaviour:
- Reset, synchronous: all entries set to 0 (invalid, clean); age[s][k] = k for every set s; FSM to IDLE; flush_* outputs 0. After reset, hit_o=0, way_o = 0 (first invalid way), tag_o and data_o = 0. A reset during a flush aborts it, with no done pulse.
- Lookup is combinational. Way k hits when its valid bit = 1 and its stored tag equals tag_i[TAG_W-1:0]. At most one way hits (the controller guarantees this). The dirty bit is ignored in the compare.
- Victim selection: the lowest-index invalid way; otherwise the way whose age = WAYS-1.
- Ages per set form a permutation of 0..WAYS-1, with 0 = MRU. A touch of way w sets age[w]=0 and increments every age < old age[w]. At most one touch per cycle.
- Clock edge with enable_i=1 in IDLE:
  - write_i=1, hit: overwrite the hit way's entry and line; touch it.
  - write_i=1, miss: overwrite the victim way with tag_i/data_i; touch it.
  - write_i=0, hit: touch the hit way; no data change.
  - write_i=0, miss: no state change.
- While flush_busy_o=1: enable_i and write_i are ignored (no writes, no LRU change); hit_o is forced 0.
- Flush FSM, states IDLE, SCAN, OFFER, DONE:
  - IDLE: flush_i=1 latches flush_inv_i, clears the entry pointer (set 0, way 0), and goes to SCAN. An access in the same cycle is performed normally.
  - SCAN: examines one entry per cycle, in order set-major, way-minor.
    - Valid and dirty: go to OFFER, holding the pointer.
    - Otherwise: if inv is latched, clear the valid bit; advance the pointer. After the last entry, go to DONE.
  - OFFER: flush_valid_o=1 with flush_set_o, flush_tag_o and flush_data_o stable until flush_ready_i=1.
    - On the handshake edge: clear the dirty bit, and the valid bit too if inv is latched; advance the pointer; go to SCAN, or to DONE after the last entry.
    - flush_valid_o never drops without a handshake.
  - DONE: flush_done_o=1 for exactly one cycle, then IDLE.
- flush_busy_o=1 in SCAN, OFFER and DONE. flush_i is ignored while busy.
- LRU ages are unchanged by a flush. Invalidated ways become preferred victims through the invalid-first rule.
- Flush latency, clean cache: flush_i sampled at edge 0 gives SCAN in cycles 1..WAYS*SETS, DONE in cycle WAYS*SETS+1, and IDLE after that. Each dirty line adds 1 OFFER cycle plus any ready stall.

Test Plan:
- Reset, then read set 3 with tag 0x12 -> hit_o=0, way_o=0, tag_o=0, data_o=0.
- Defaults: fill set 5 with tags 0xA, 0xB, 0xC, 0xD -> land in ways 0..3. Read 0xA (hit, way 0), then fill 0xE -> victim way 1 (tag 0xB replaced); a later read of 0xB misses.
- Write hit to set 5 tag 0xC with the dirty bit set and data 0xFF..FF -> next read hits way 2 with tag_o dirty=1 and data 0xFF..FF; LRU order updated so way 2 has age 0.
- Two dirty lines (set 0 way 1, set 7 way 3), flush with inv=0, flush_ready_i held low 3 cycles on the first offer:
  - offers appear in order with flush_valid_o held through the stall;
  - dirty bits clear while valid bits stay 1;
  - flush_done_o pulses at cycle 64+2+3+1 = 70.
- Flush with inv=1 on a full cache -> after done, every lookup misses and way_o=0 for all sets.
- Reset asserted mid-OFFER -> next cycle flush_busy_o=0 and flush_valid_o=0 with no done pulse; all lookups miss. An access issued during busy leaves the array unchanged.

Source files
------------

// File: rtl/dcache_sram_nway.sv
// N-way set-associative data-cache storage with true-LRU replacement and a
// flush/invalidate walker that offers dirty lines to memory over valid/ready.
module dcache_sram_nway #(
  parameter int WAYS   = 4,
  parameter int SETS   = 16,
  parameter int TAG_W  = 23,
  parameter int LINE_W = 256,
  localparam int WAY_W = $clog2(WAYS),
  localparam int IDX_W = $clog2(SETS),
  localparam int ENT_W = TAG_W + 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [ENT_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic [ENT_W-1:0]  tag_o,
  output logic [LINE_W-1:0] data_o,
  output logic              hit_o,
  output logic [WAY_W-1:0]  way_o,
  input  logic              flush_i,
  input  logic              flush_inv_i,
  output logic              flush_busy_o,
  output logic              flush_valid_o,
  input  logic              flush_ready_i,
  output logic [IDX_W-1:0]  flush_set_o,
  output logic [TAG_W-1:0]  flush_tag_o,
  output logic [LINE_W-1:0] flush_data_o,
  output logic              flush_done_o
);

  localparam int PTR_W = IDX_W + WAY_W;

  typedef enum logic [1:0] {IDLE, SCAN, OFFER, DONE} state_t;

  logic [ENT_W-1:0]  tag_mem  [SETS][WAYS];
  logic [LINE_W-1:0] data_mem [SETS][WAYS];
  logic [WAY_W-1:0]  age_mem  [SETS][WAYS];

  state_t            state;
  logic [PTR_W-1:0]  ptr;
  logic              inv_q;
  logic              busy_q;
  logic              valid_q;
  logic              done_q;
  logic [IDX_W-1:0]  fset_q;
  logic [TAG_W-1:0]  ftag_q;
  logic [LINE_W-1:0] fdata_q;

  logic              any_hit;
  logic [WAY_W-1:0]  hit_way;
  logic              inv_found;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  lru_way;
  logic [WAY_W-1:0]  sel_way;
  logic              lookup_hit;
  logic              access_en;

  logic [IDX_W-1:0]  ptr_set;
  logic [WAY_W-1:0]  ptr_way;
  logic [ENT_W-1:0]  cur_ent;
  logic              cur_dirty_valid;
  logic              ptr_last;
  logic              scan_clr;
  logic              offer_hs;

  // Tag compare and victim choice for the addressed set (invalid-first, then LRU).
  always_comb begin
    any_hit   = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int k = 0; k < WAYS; k++) begin
      if (tag_mem[addr_i][k][TAG_W+1] &&
          (tag_mem[addr_i][k][TAG_W-1:0] == tag_i[TAG_W-1:0])) begin
        any_hit = 1'b1;
        hit_way = WAY_W'(k);
      end
      if (age_mem[addr_i][k] == WAY_W'(WAYS-1))
        lru_way = WAY_W'(k);
    end
    for (int k = WAYS-1; k >= 0; k--) begin
      if (!tag_mem[addr_i][k][TAG_W+1]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(k);
      end
    end
  end

  assign lookup_hit = any_hit && !busy_q;
  assign sel_way    = lookup_hit ? hit_way : (inv_found ? inv_way : lru_way);
  assign access_en  = enable_i && (state == IDLE);

  assign hit_o  = lookup_hit;
  assign way_o  = sel_way;
  assign tag_o  = tag_mem[addr_i][sel_way];
  assign data_o = data_mem[addr_i][sel_way];

  assign ptr_set         = ptr[PTR_W-1:WAY_W];
  assign ptr_way         = ptr[WAY_W-1:0];
  assign cur_ent         = tag_mem[ptr_set][ptr_way];
  assign cur_dirty_valid = cur_ent[TAG_W+1] && cur_ent[TAG_W];
  assign ptr_last        = (ptr == {PTR_W{1'b1}});
  assign scan_clr        = (state == SCAN) && !cur_dirty_valid && inv_q;
  assign offer_hs        = (state == OFFER) && flush_ready_i;

  // Array and LRU state: normal accesses only in IDLE, walker bit clears otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int k = 0; k < WAYS; k++) begin
          tag_mem[s][k]  <= '0;
          data_mem[s][k] <= '0;
          age_mem[s][k]  <= WAY_W'(k);
        end
      end
    end else begin
      if (access_en) begin
        if (write_i) begin
          tag_mem[addr_i][sel_way]  <= tag_i;
          data_mem[addr_i][sel_way] <= data_i;
        end
        if (write_i || any_hit) begin
          for (int k = 0; k < WAYS; k++) begin
            if (WAY_W'(k) == sel_way)
              age_mem[addr_i][k] <= '0;
            else if (age_mem[addr_i][k] < age_mem[addr_i][sel_way])
              age_mem[addr_i][k] <= age_mem[addr_i][k] + 1'b1;
          end
        end
      end
      if (scan_clr)
        tag_mem[ptr_set][ptr_way][TAG_W+1] <= 1'b0;
      if (offer_hs) begin
        tag_mem[ptr_set][ptr_way][TAG_W] <= 1'b0;
        if (inv_q)
          tag_mem[ptr_set][ptr_way][TAG_W+1] <= 1'b0;
      end
    end
  end

  // Flush walker: one entry per SCAN cycle, OFFER holds until the memory side takes it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      ptr     <= '0;
      inv_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      fset_q  <= '0;
      ftag_q  <= '0;
      fdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (flush_i) begin
            inv_q  <= flush_inv_i;
            ptr    <= '0;
            busy_q <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (cur_dirty_valid) begin
            valid_q <= 1'b1;
            fset_q  <= ptr_set;
            ftag_q  <= cur_ent[TAG_W-1:0];
            fdata_q <= data_mem[ptr_set][ptr_way];
            state   <= OFFER;
          end else begin
            ptr <= ptr + 1'b1;
            if (ptr_last) begin
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
        end
        OFFER: begin
          if (flush_ready_i) begin
            valid_q <= 1'b0;
            fset_q  <= '0;
            ftag_q  <= '0;
            fdata_q <= '0;
            ptr     <= ptr + 1'b1;
            if (ptr_last) begin
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              state  <= SCAN;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign flush_busy_o  = busy_q;
  assign flush_valid_o = valid_q;
  assign flush_done_o  = done_q;
  assign flush_set_o   = fset_q;
  assign flush_tag_o   = ftag_q;
  assign flush_data_o  = fdata_q;

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Directed self-checking bench for dcache_sram_nway: lookup/fill/LRU, flush
// with and without invalidate, and reset/busy interactions.
module tb_dcache_sram_nway;

  localparam int WAYS = 4, SETS = 16, TAG_W = 23, LINE_W = 256;
  localparam int WAY_W = 2, IDX_W = 4, ENT_W = 25;
  localparam logic [LINE_W-1:0] D1 = {8{32'hD1D1_0001}};
  localparam logic [LINE_W-1:0] D2 = {8{32'hD2D2_0002}};
  localparam logic [LINE_W-1:0] DE = {8{32'hEEEE_0001}};
  localparam logic [LINE_W-1:0] DX = {8{32'hABCD_1234}};
  localparam logic [LINE_W-1:0] DY = {8{32'h5555_AAAA}};

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [IDX_W-1:0]  addr_i = '0;
  logic [ENT_W-1:0]  tag_i = '0;
  logic [LINE_W-1:0] data_i = '0;
  logic              enable_i = 1'b0, write_i = 1'b0;
  logic [ENT_W-1:0]  tag_o;
  logic [LINE_W-1:0] data_o;
  logic              hit_o;
  logic [WAY_W-1:0]  way_o;
  logic              flush_i = 1'b0, flush_inv_i = 1'b0, flush_ready_i = 1'b0;
  logic              flush_busy_o, flush_valid_o, flush_done_o;
  logic [IDX_W-1:0]  flush_set_o;
  logic [TAG_W-1:0]  flush_tag_o;
  logic [LINE_W-1:0] flush_data_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  dcache_sram_nway #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .tag_i(tag_i), .data_i(data_i),
    .enable_i(enable_i), .write_i(write_i), .tag_o(tag_o), .data_o(data_o),
    .hit_o(hit_o), .way_o(way_o), .flush_i(flush_i), .flush_inv_i(flush_inv_i),
    .flush_busy_o(flush_busy_o), .flush_valid_o(flush_valid_o),
    .flush_ready_i(flush_ready_i), .flush_set_o(flush_set_o),
    .flush_tag_o(flush_tag_o), .flush_data_o(flush_data_o),
    .flush_done_o(flush_done_o)
  );

  function automatic logic [ENT_W-1:0] ent(input logic v, input logic d, input logic [TAG_W-1:0] t);
    return {v, d, t};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [IDX_W-1:0] a, input logic [ENT_W-1:0] t,
                       input logic [LINE_W-1:0] d, input logic en, input logic wr);
    addr_i = a; tag_i = t; data_i = d; enable_i = en; write_i = wr;
    #1;
  endtask

  task automatic fill(input logic [IDX_W-1:0] a, input logic [ENT_W-1:0] t, input logic [LINE_W-1:0] d);
    drive(a, t, d, 1'b1, 1'b1);
    tick();
    enable_i = 1'b0; write_i = 1'b0;
  endtask

  task automatic do_reset();
    enable_i = 1'b0; write_i = 1'b0; flush_i = 1'b0; flush_ready_i = 1'b0;
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(4'd3, ent(1'b1, 1'b0, 23'h12), '0, 1'b0, 1'b0);
    checks++; if (hit_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_hit got=%0b exp=0", hit_o); end
    checks++; if (way_o !== 2'd0) begin failures++; $display("[TB] FAIL reset_way got=%0d exp=0", way_o); end
    checks++; if (tag_o !== '0) begin failures++; $display("[TB] FAIL reset_tag got=%h exp=0", tag_o); end
    checks++; if (data_o !== '0) begin failures++; $display("[TB] FAIL reset_data got=%h exp=0", data_o); end
    checks++;
    if ({flush_busy_o, flush_valid_o, flush_done_o} !== 3'b000) begin
      failures++; $display("[TB] FAIL reset_flush_flags got=%b exp=000", {flush_busy_o, flush_valid_o, flush_done_o});
    end
  endtask

  task automatic test_fill_lru();
    logic [TAG_W-1:0] tags [4];
    tags = '{23'hA, 23'hB, 23'hC, 23'hD};
    for (int i = 0; i < 4; i++) begin
      drive(4'd5, ent(1'b1, 1'b0, tags[i]), '0, 1'b0, 1'b0);
      checks++;
      if (hit_o !== 1'b0 || way_o !== WAY_W'(i)) begin
        failures++; $display("[TB] FAIL fill_victim%0d got hit=%0b way=%0d exp hit=0 way=%0d", i, hit_o, way_o, i);
      end
      fill(4'd5, ent(1'b1, 1'b0, tags[i]), {8{32'h5000_0000 + i}});
    end
    drive(4'd5, ent(1'b1, 1'b0, 23'hA), '0, 1'b1, 1'b0);
    checks++;
    if (hit_o !== 1'b1 || way_o !== 2'd0) begin
      failures++; $display("[TB] FAIL read_a got hit=%0b way=%0d exp hit=1 way=0", hit_o, way_o);
    end
    tick();
    drive(4'd5, ent(1'b1, 1'b0, 23'hE), '0, 1'b0, 1'b0);
    checks++;
    if (hit_o !== 1'b0 || way_o !== 2'd1) begin
      failures++; $display("[TB] FAIL lru_victim got hit=%0b way=%0d exp hit=0 way=1", hit_o, way_o);
    end
    fill(4'd5, ent(1'b1, 1'b0, 23'hE), DE);
    drive(4'd5, ent(1'b1, 1'b0, 23'hB), '0, 1'b0, 1'b0);
    checks++;
    if (hit_o !== 1'b0 || way_o !== 2'd2) begin
      failures++; $display("[TB] FAIL read_b_miss got hit=%0b way=%0d exp hit=0 way=2", hit_o, way_o);
    end
    drive(4'd5, ent(1'b1, 1'b0, 23'hE), '0, 1'b0, 1'b0);
    checks++;
    if (hit_o !== 1'b1 || way_o !== 2'd1 || data_o !== DE) begin
      failures++; $display("[TB] FAIL read_e got hit=%0b way=%0d data=%h exp hit=1 way=1 data=%h", hit_o, way_o, data_o, DE);
    end
  endtask

  task automatic test_write_hit();
    drive(4'd5, ent(1'b1, 1'b1, 23'hC), '1, 1'b1, 1'b1);
    checks++;
    if (hit_o !== 1'b1 || way_o !== 2'd2) begin
      failures++; $display("[TB] FAIL wr_hit got hit=%0b way=%0d exp hit=1 way=2", hit_o, way_o);
    end
    tick();
    drive(4'd5, ent(1'b1, 1'b0, 23'hC), '0, 1'b0, 1'b0);
    checks++;
    if (hit_o !== 1'b1 || way_o !== 2'd2 || tag_o !== ent(1'b1, 1'b1, 23'hC) || data_o !== '1) begin
      failures++; $display("[TB] FAIL wr_hit_read got hit=%0b way=%0d tag=%h data=%h exp hit=1 way=2 tag=%h data=all-ones",
                           hit_o, way_o, tag_o, data_o, ent(1'b1, 1'b1, 23'hC));
    end
    drive(4'd5, ent(1'b1, 1'b0, 23'h77), '0, 1'b0, 1'b0);
    checks++; if (way_o !== 2'd3) begin failures++; $display("[TB] FAIL lru_after_wr got=%0d exp=3", way_o); end
    drive(4'd5, ent(1'b1, 1'b0, 23'hD), '0, 1'b1, 1'b0);
    tick();
    enable_i = 1'b0;
    drive(4'd5, ent(1'b1, 1'b0, 23'h77), '0, 1'b0, 1'b0);
    checks++; if (way_o !== 2'd0) begin failures++; $display("[TB] FAIL lru_after_read got=%0d exp=0", way_o); end
  endtask

  task automatic test_flush_noinv();
    int cyc, offers, first_off, second_off, done_cyc, done_cnt, stall;
    bit ended;
    offers = 0; first_off = 0; second_off = 0; done_cyc = 0; done_cnt = 0; stall = 0; ended = 0;
    do_reset();
    fill(4'd0, ent(1'b1, 1'b0, 23'h100), DE);
    fill(4'd0, ent(1'b1, 1'b1, 23'h101), D1);
    for (int w = 0; w < 3; w++) fill(4'd7, ent(1'b1, 1'b0, 23'(23'h700 + w)), DY);
    fill(4'd7, ent(1'b1, 1'b1, 23'h703), D2);
    flush_i = 1'b1; flush_inv_i = 1'b0; flush_ready_i = 1'b0;
    tick();
    flush_i = 1'b0;
    for (cyc = 1; cyc <= 120; cyc++) begin
      if (flush_valid_o) begin
        if (offers == 0) begin
          if (first_off == 0) first_off = cyc;
          checks++;
          if (flush_set_o !== 4'd0 || flush_tag_o !== 23'h101 || flush_data_o !== D1) begin
            failures++; $display("[TB] FAIL offer1_c%0d got set=%0d tag=%h exp set=0 tag=101 data=D1", cyc, flush_set_o, flush_tag_o);
          end
          flush_ready_i = (stall >= 3);
          stall++;
          if (flush_ready_i) offers = 1;
        end else if (offers == 1) begin
          second_off = cyc;
          checks++;
          if (flush_set_o !== 4'd7 || flush_tag_o !== 23'h703 || flush_data_o !== D2) begin
            failures++; $display("[TB] FAIL offer2 got set=%0d tag=%h exp set=7 tag=703 data=D2", flush_set_o, flush_tag_o);
          end
          flush_ready_i = 1'b1;
          offers = 2;
        end else begin
          offers++;
        end
      end else begin
        flush_ready_i = 1'b0;
      end
      if (flush_done_o) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (!flush_busy_o && cyc > 1) begin ended = 1; break; end
      tick();
    end
    flush_ready_i = 1'b0;
    checks++; if (!ended) begin failures++; $display("[TB] FAIL flush1_timeout got busy=%0b exp busy=0", flush_busy_o); end
    checks++; if (first_off != 3) begin failures++; $display("[TB] FAIL offer1_cycle got=%0d exp=3", first_off); end
    checks++; if (stall != 4) begin failures++; $display("[TB] FAIL offer1_hold got=%0d exp=4", stall); end
    checks++; if (second_off != 37) begin failures++; $display("[TB] FAIL offer2_cycle got=%0d exp=37", second_off); end
    checks++; if (offers != 2) begin failures++; $display("[TB] FAIL offer_count got=%0d exp=2", offers); end
    checks++; if (done_cyc != 70) begin failures++; $display("[TB] FAIL done_cycle got=%0d exp=70", done_cyc); end
    checks++; if (done_cnt != 1) begin failures++; $display("[TB] FAIL done_width got=%0d exp=1", done_cnt); end
    drive(4'd0, ent(1'b1, 1'b0, 23'h101), '0, 1'b0, 1'b0);
    checks++;
    if (hit_o !== 1'b1 || way_o !== 2'd1 || tag_o !== ent(1'b1, 1'b0, 23'h101) || data_o !== D1) begin
      failures++; $display("[TB] FAIL clean_s0 got hit=%0b way=%0d tag=%h exp hit=1 way=1 tag=%h", hit_o, way_o, tag_o, ent(1'b1, 1'b0, 23'h101));
    end
    drive(4'd7, ent(1'b1, 1'b0, 23'h703), '0, 1'b0, 1'b0);
    checks++;
    if (hit_o !== 1'b1 || way_o !== 2'd3 || tag_o !== ent(1'b1, 1'b0, 23'h703)) begin
      failures++; $display("[TB] FAIL clean_s7 got hit=%0b way=%0d tag=%h exp hit=1 way=3 tag=%h", hit_o, way_o, tag_o, ent(1'b1, 1'b0, 23'h703));
    end
  endtask

  task automatic test_flush_inv();
    int cyc, offers, done_cyc;
    offers = 0; done_cyc = 0;
    do_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        fill(IDX_W'(s), ent(1'b1, w == 0, 23'(s * 16 + w + 'h200)), {8{32'(s * 16 + w)}});
    flush_i = 1'b1; flush_inv_i = 1'b1; flush_ready_i = 1'b1;
    tick();
    flush_i = 1'b0; flush_inv_i = 1'b0;
    for (cyc = 1; cyc <= 300; cyc++) begin
      if (flush_valid_o) offers++;
      if (flush_done_o) begin done_cyc = cyc; break; end
      tick();
    end
    tick();
    flush_ready_i = 1'b0;
    checks++; if (done_cyc != 81) begin failures++; $display("[TB] FAIL inv_done_cycle got=%0d exp=81", done_cyc); end
    checks++; if (offers != 16) begin failures++; $display("[TB] FAIL inv_offers got=%0d exp=16", offers); end
    for (int s = 0; s < SETS; s++) begin
      drive(IDX_W'(s), ent(1'b1, 1'b0, 23'(s * 16 + 'h203)), '0, 1'b0, 1'b0);
      checks++;
      if (hit_o !== 1'b0 || way_o !== 2'd0) begin
        failures++; $display("[TB] FAIL inv_set%0d got hit=%0b way=%0d exp hit=0 way=0", s, hit_o, way_o);
      end
    end
  endtask

  task automatic test_busy_and_reset();
    int cyc, done_seen;
    done_seen = 0;
    do_reset();
    fill(4'd2, ent(1'b1, 1'b1, 23'h22), DX);
    flush_i = 1'b1; flush_inv_i = 1'b0; flush_ready_i = 1'b0;
    tick();
    flush_i = 1'b0;
    cyc = 1;
    drive(4'd2, ent(1'b1, 1'b0, 23'h22), DY, 1'b1, 1'b1);
    checks++; if (hit_o !== 1'b0) begin failures++; $display("[TB] FAIL busy_hit_forced got=%0b exp=0", hit_o); end
    tick(); cyc++;
    drive(4'd4, ent(1'b1, 1'b0, 23'h44), DY, 1'b1, 1'b1);
    tick(); cyc++;
    enable_i = 1'b0; write_i = 1'b0;
    while (!flush_valid_o && cyc < 40) begin tick(); cyc++; end
    checks++; if (cyc != 10) begin failures++; $display("[TB] FAIL busy_offer_cycle got=%0d exp=10", cyc); end
    checks++;
    if (flush_set_o !== 4'd2 || flush_tag_o !== 23'h22 || flush_data_o !== DX) begin
      failures++; $display("[TB] FAIL busy_offer got set=%0d tag=%h data=%h exp set=2 tag=22 data=%h", flush_set_o, flush_tag_o, flush_data_o, DX);
    end
    drive(4'd4, ent(1'b1, 1'b0, 23'h44), '0, 1'b0, 1'b0);
    checks++;
    if (tag_o !== '0 || data_o !== '0) begin
      failures++; $display("[TB] FAIL busy_write_ignored got tag=%h exp tag=0 data=0", tag_o);
    end
    tick(); tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++;
    if ({flush_busy_o, flush_valid_o, flush_done_o} !== 3'b000) begin
      failures++; $display("[TB] FAIL mid_reset_flags got=%b exp=000", {flush_busy_o, flush_valid_o, flush_done_o});
    end
    for (int i = 0; i < 5; i++) begin
      if (flush_done_o || flush_busy_o) done_seen++;
      tick();
    end
    checks++; if (done_seen != 0) begin failures++; $display("[TB] FAIL mid_reset_no_done got=%0d exp=0", done_seen); end
    drive(4'd2, ent(1'b1, 1'b0, 23'h22), '0, 1'b0, 1'b0);
    checks++;
    if (hit_o !== 1'b0 || way_o !== 2'd0) begin
      failures++; $display("[TB] FAIL mid_reset_lookup got hit=%0b way=%0d exp hit=0 way=0", hit_o, way_o);
    end
  endtask

  initial begin
    test_reset();
    test_fill_lru();
    test_write_hit();
    test_flush_noinv();
    test_flush_inv();
    test_busy_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
